// File: rtl/minisrc_control_sequencer.sv
// Hardwired MiniSRC control unit: steps each instruction through fetch/decode/execute
// T-states and drives the register select encoder plus datapath and memory strobes.

module minisrc_control_checker (
    input logic clock,
    input logic reset_n,
    input logic gra,
    input logic grb,
    input logic grc,
    input logic rin,
    input logic rout,
    input logic baout,
    input logic read,
    input logic write
);
    a_one_select: assert property (@(posedge clock) disable iff (!reset_n)
        (rin || rout) |-> $onehot({gra, grb, grc}));
    a_baout_rout: assert property (@(posedge clock) disable iff (!reset_n) !(baout && rout));
    a_read_write: assert property (@(posedge clock) disable iff (!reset_n) !(read && write));
endmodule

module minisrc_control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     ir,
    input  logic            mem_ack,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            baout,
    output logic            pc_out,
    output logic            pc_in,
    output logic            inc_pc,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            zlo_out,
    output logic            c_out,
    output logic            read,
    output logic            write,
    output logic [ALUW-1:0] alu_op,
    output logic [2:0]      step,
    output logic            run
);
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7, S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_LD, C_LDI, C_ST, C_RTYPE, C_ITYPE, C_NOP, C_HALT
    } op_class_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in;
        logic mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out, read, write;
        logic [ALUW-1:0] alu_op;
    } ctrl_t;

    function automatic op_class_t classify(input logic [OPW-1:0] op);
        case (op)
            5'b00000: return C_LD;
            5'b00001: return C_LDI;
            5'b00010: return C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_RTYPE;
            5'b01100, 5'b01101, 5'b01110: return C_ITYPE;
            5'b11011: return C_HALT;
            default: return C_NOP;
        endcase
    endfunction

    function automatic logic [ALUW-1:0] alu_sel(input logic [OPW-1:0] op);
        case (op)
            5'b00100:          return 4'd1;
            5'b00101, 5'b01101: return 4'd2;
            5'b00110, 5'b01110: return 4'd3;
            default:           return 4'd0;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op);
        ctrl_t c;
        op_class_t cls;
        c = '0;
        cls = classify(op);
        case (s)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
            S_T1: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: begin
                case (cls)
                    C_RTYPE, C_ITYPE: begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
                    C_LD, C_LDI, C_ST: begin c.grb = 1'b1; c.baout = 1'b1; c.y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_RTYPE: begin c.grc = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu_op = alu_sel(op); end
                    C_ITYPE: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = alu_sel(op); end
                    C_LD, C_LDI, C_ST: begin c.c_out = 1'b1; c.z_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_RTYPE, C_ITYPE, C_LDI: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    C_LD, C_ST: begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin c.read = 1'b1; c.mdr_in = 1'b1; end
                    C_ST: begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    C_ST: c.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] step_of(input state_t s);
        logic [3:0] v;
        v = s;
        if (s == S_HALT) return 3'd3;
        else return v[2:0];
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [OPW-1:0]  opcode_r;
    logic [OPW-1:0]  op_next_s;
    op_class_t       cls_s;
    logic            started_r;
    ctrl_t           ctrl_r;
    logic [2:0]      step_r;
    logic            run_r;

    // Next T-step; the first cycle after reset holds T0 so its strobes get one visible cycle.
    always_comb begin
        state_next_s = S_T0;
        op_next_s = (state_r == S_T2) ? ir[31:27] : opcode_r;
        cls_s = classify(op_next_s);
        if (!started_r) begin
            state_next_s = S_T0;
        end else begin
            case (state_r)
                S_T0: state_next_s = S_T1;
                S_T1: state_next_s = mem_ack ? S_T2 : S_T1;
                S_T2: state_next_s = (cls_s == C_HALT) ? S_HALT : S_T3;
                S_T3: state_next_s = (cls_s == C_NOP) ? S_T0 : S_T4;
                S_T4: state_next_s = S_T5;
                S_T5: state_next_s = (cls_s == C_LD || cls_s == C_ST) ? S_T6 : S_T0;
                S_T6: state_next_s = (cls_s == C_ST || mem_ack) ? S_T7 : S_T6;
                S_T7: state_next_s = (cls_s == C_ST && !mem_ack) ? S_T7 : S_T0;
                S_HALT: state_next_s = S_HALT;
                default: state_next_s = S_T0;
            endcase
        end
    end

    // State, opcode latch and registered Moore outputs decoded from the upcoming step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_T0;
            opcode_r  <= '0;
            started_r <= 1'b0;
            ctrl_r    <= '0;
            step_r    <= 3'd0;
            run_r     <= 1'b1;
        end else begin
            started_r <= 1'b1;
            state_r   <= state_next_s;
            if (state_r == S_T2) opcode_r <= ir[31:27];
            ctrl_r    <= decode(state_next_s, op_next_s);
            step_r    <= step_of(state_next_s);
            run_r     <= (state_next_s != S_HALT);
        end
    end

    assign {gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in,
            mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out, read, write} =
           {ctrl_r.gra, ctrl_r.grb, ctrl_r.grc, ctrl_r.rin, ctrl_r.rout, ctrl_r.baout,
            ctrl_r.pc_out, ctrl_r.pc_in, ctrl_r.inc_pc, ctrl_r.mar_in, ctrl_r.mdr_in,
            ctrl_r.mdr_out, ctrl_r.ir_in, ctrl_r.y_in, ctrl_r.z_in, ctrl_r.zlo_out,
            ctrl_r.c_out, ctrl_r.read, ctrl_r.write};
    assign alu_op = ctrl_r.alu_op;
    assign step   = step_r;
    assign run    = run_r;

    minisrc_control_checker u_checker (
        .clock(clock), .reset_n(reset_n), .gra(gra), .grb(grb), .grc(grc),
        .rin(rin), .rout(rout), .baout(baout), .read(read), .write(write)
    );
endmodule

// File: tb/tb_minisrc_control_sequencer.sv
// Directed bench for the MiniSRC control sequencer: fetch, R/I-type, ld/st, nop and halt flows.

module tb_minisrc_control_sequencer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        mem_ack;
    logic gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in;
    logic mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out, read, write;
    logic [3:0]  alu_op;
    logic [2:0]  step;
    logic        run;
    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [18:0] GRA = 19'd1 << 18, GRB = 19'd1 << 17, GRC = 19'd1 << 16;
    localparam logic [18:0] RIN = 19'd1 << 15, ROUT = 19'd1 << 14, BAOUT = 19'd1 << 13;
    localparam logic [18:0] PC_OUT = 19'd1 << 12, PC_IN = 19'd1 << 11, INC_PC = 19'd1 << 10;
    localparam logic [18:0] MAR_IN = 19'd1 << 9, MDR_IN = 19'd1 << 8, MDR_OUT = 19'd1 << 7;
    localparam logic [18:0] IR_IN = 19'd1 << 6, Y_IN = 19'd1 << 5, Z_IN = 19'd1 << 4;
    localparam logic [18:0] ZLO_OUT = 19'd1 << 3, C_OUT = 19'd1 << 2, READ = 19'd1 << 1;
    localparam logic [18:0] WRITE = 19'd1;
    localparam logic [18:0] T0_C = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [18:0] T1_C = ZLO_OUT | PC_IN | READ | MDR_IN;
    localparam logic [18:0] T2_C = MDR_OUT | IR_IN;

    wire [18:0] ctrl = {gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in,
                        mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out, read, write};

    minisrc_control_sequencer #(.OPW(5), .ALUW(4)) dut (
        .clock(clock), .reset_n(reset_n), .ir(ir), .mem_ack(mem_ack),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlo_out(zlo_out), .c_out(c_out), .read(read), .write(write),
        .alu_op(alu_op), .step(step), .run(run)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] s, input logic [18:0] c,
                               input logic [3:0] a, input logic r);
        check({tag, " step"}, 32'(step), 32'(s));
        check({tag, " ctrl"}, 32'(ctrl), 32'(c));
        check({tag, " alu"}, 32'(alu_op), 32'(a));
        check({tag, " run"}, 32'(run), 32'(r));
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic fetch(input string tag);
        mem_ack = 1'b1;
        cycle(); check_state({tag, " T1"}, 3'd1, T1_C, 4'd0, 1'b1);
        cycle(); check_state({tag, " T2"}, 3'd2, T2_C, 4'd0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; mem_ack = 1'b0; ir = 32'h0;
        repeat (2) @(negedge clock);
        check_state("rst", 3'd0, 19'd0, 4'd0, 1'b1);
        reset_n = 1'b1;
        cycle(); check_state("idle T0", 3'd0, T0_C, 4'd0, 1'b1);
        cycle(); check_state("wait T1a", 3'd1, T1_C, 4'd0, 1'b1);
        cycle(); check_state("wait T1b", 3'd1, T1_C, 4'd0, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_state("rst mid", 3'd0, 19'd0, 4'd0, 1'b1);
        @(negedge clock) reset_n = 1'b1;
        cycle(); check_state("rel T0", 3'd0, T0_C, 4'd0, 1'b1);

        // add R1 <- R2 + R3
        ir = 32'h18918000;
        fetch("add");
        cycle(); check_state("add T3", 3'd3, GRB | ROUT | Y_IN, 4'd0, 1'b1);
        cycle(); check_state("add T4", 3'd4, GRC | ROUT | Z_IN, 4'd0, 1'b1);
        cycle(); check_state("add T5", 3'd5, ZLO_OUT | GRA | RIN, 4'd0, 1'b1);
        cycle(); check_state("add T0", 3'd0, T0_C, 4'd0, 1'b1);

        // ld with three wait cycles on the data read
        ir = 32'h00880005;
        fetch("ld");
        cycle(); check_state("ld T3", 3'd3, GRB | BAOUT | Y_IN, 4'd0, 1'b1);
        cycle(); check_state("ld T4", 3'd4, C_OUT | Z_IN, 4'd0, 1'b1);
        cycle(); check_state("ld T5", 3'd5, ZLO_OUT | MAR_IN, 4'd0, 1'b1);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(); check_state($sformatf("ld T6 w%0d", i), 3'd6, READ | MDR_IN, 4'd0, 1'b1);
        end
        mem_ack = 1'b1;
        cycle(); check_state("ld T7", 3'd7, MDR_OUT | GRA | RIN, 4'd0, 1'b1);
        cycle(); check_state("ld T0", 3'd0, T0_C, 4'd0, 1'b1);

        // st with two wait cycles on the write
        ir = 32'h10880005;
        fetch("st");
        cycle(); check_state("st T3", 3'd3, GRB | BAOUT | Y_IN, 4'd0, 1'b1);
        cycle(); check_state("st T4", 3'd4, C_OUT | Z_IN, 4'd0, 1'b1);
        mem_ack = 1'b0;
        cycle(); check_state("st T5", 3'd5, ZLO_OUT | MAR_IN, 4'd0, 1'b1);
        cycle(); check_state("st T6", 3'd6, GRA | ROUT | MDR_IN, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(); check_state($sformatf("st T7 w%0d", i), 3'd7, WRITE, 4'd0, 1'b1);
        end
        mem_ack = 1'b1;
        cycle(); check_state("st T0", 3'd0, T0_C, 4'd0, 1'b1);

        // andi
        ir = 32'h6888000F;
        fetch("andi");
        cycle(); check_state("andi T3", 3'd3, GRB | ROUT | Y_IN, 4'd0, 1'b1);
        cycle(); check_state("andi T4", 3'd4, C_OUT | Z_IN, 4'd2, 1'b1);
        cycle(); check_state("andi T5", 3'd5, ZLO_OUT | GRA | RIN, 4'd0, 1'b1);
        cycle(); check_state("andi T0", 3'd0, T0_C, 4'd0, 1'b1);

        // illegal opcode behaves as nop
        ir = 32'hF8000000;
        fetch("ill");
        cycle(); check_state("ill T3", 3'd3, 19'd0, 4'd0, 1'b1);
        cycle(); check_state("ill T0", 3'd0, T0_C, 4'd0, 1'b1);

        // halt holds until reset regardless of mem_ack
        ir = 32'hD8000000;
        fetch("halt");
        for (int i = 0; i < 20; i++) begin
            mem_ack = i[0];
            cycle(); check_state($sformatf("halt c%0d", i), 3'd3, 19'd0, 4'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/minisrc_control_sequencer.md
Name: minisrc_control_sequencer

Overview:
- Hardwired control unit for the MiniSRC datapath; the driving end of the register select/encode interface.
- Walks each instruction through fetch, decode and execute T-steps, one step per clock.
- Per step it issues Gra/Grb/Grc/Rin/Rout/BAout to the select encoder, plus bus-enable, register-load, ALU and memory-handshake strobes.
- Sits between the IR and the datapath.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALUW, 4, alu_op width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents; opcode = ir[31:27].
- mem_ack  in  1  memory completion; sampled high ends a Read/Write step.
- gra, grb, grc  out  1 each  Ra/Rb/Rc field select to the encoder.
- rin, rout, baout  out  1 each  register-file in/out strobes; baout = base-address out (R0 reads as 0).
- pc_out, pc_in, inc_pc  out  1 each  PC bus-out, load and increment.
- mar_in, mdr_in, mdr_out  out  1 each  MAR/MDR controls.
- ir_in, y_in, z_in, zlo_out, c_out  out  1 each  IR load, Y load, Z load, Zlow bus-out, sign-extended C out.
- read, write  out  1 each  memory request strobes.
- alu_op  out  ALUW  0=ADD, 1=SUB, 2=AND, 3=OR; 0 when idle.
- step  out  3  current T-step index (debug).
- run  out  1  high until HALT executes.

Behaviour:
- Control outputs are a Moore decode of (state, latched opcode): all 0 except in the step that uses them.
- Async reset: state T0, opcode latch 0, run=1, every other output 0 immediately, including read/write mid-handshake.
- Opcode latch loads from ir[31:27] on the clock edge leaving T2.

Opcodes:
- ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110.
- addi 01100, andi 01101, ori 01110, nop 11010, halt 11011.
- Any other code executes as nop.

Fetch (all instructions):
- T0: pc_out, mar_in, inc_pc, z_in.
- T1: zlo_out, pc_in, read, mdr_in; held until mem_ack.
- T2: mdr_out, ir_in.

R-type (add/sub/and/or):
- T3: grb, rout, y_in.
- T4: grc, rout, z_in, alu_op per opcode.
- T5: zlo_out, gra, rin -> T0.

I-type (addi/andi/ori):
- T3: grb, rout, y_in.
- T4: c_out, z_in, alu_op ADD/AND/OR.
- T5: zlo_out, gra, rin -> T0.

ldi/ld/st address phase:
- T3: grb, baout, y_in.
- T4: c_out, alu_op=ADD, z_in.
- ldi: T5 zlo_out, gra, rin -> T0.
- ld/st: T5 zlo_out, mar_in.

ld tail:
- T6: read, mdr_in; held until mem_ack.
- T7: mdr_out, gra, rin -> T0.

st tail:
- T6: gra, rout, mdr_in.
- T7: write; held until mem_ack -> T0.

nop/illegal: T3 emits nothing -> T0.

halt:
- At T3 enter HALT: run=0, all strobes 0, step=3.
- Stays in HALT until reset.

Memory handshake:
- In a wait step, read/write stay high every cycle that mem_ack=0.
- The step advances on the edge where mem_ack=1; read/write drop the next cycle.
- mem_ack already high on entry means one-cycle step.
- mem_ack outside a wait step is ignored.

Invariants:
- Exactly one of gra/grb/grc high whenever rin or rout is high.
- baout never together with rout.
- read and write never both high.

Test Plan:
- Reset/idle: reset_n=0 mid-T1 with read=1 -> read=0 immediately; after release step=0, run=1; T0 shows pc_out=mar_in=inc_pc=z_in=1.
- add, ir=0x18918000 (R1<-R2+R3), mem_ack tied 1:
  - T1-T5 in 5 cycles after T0.
  - T3 grb+rout+y_in; T4 grc+rout+z_in, alu_op=0; T5 gra+rin; then step=0.
- ld, ir=0x00880005, mem_ack held low 3 cycles in T6:
  - read=1 for 4 cycles, step stays 6.
  - T3 baout=1, rout=0; T7 mdr_out+gra+rin.
- st, ir=0x10880005:
  - T6 gra+rout+mdr_in.
  - T7 write=1 until mem_ack; read never 1 after T1.
- andi, ir=0x6888000F -> T4 c_out=1, alu_op=2, grc=0.
- halt (ir=0xD8000000) and illegal (ir=0xF8000000):
  - halt: run=0, outputs frozen at 0 for 20 cycles despite mem_ack toggling.
  - illegal: T3 all-zero, then T0.
